mar_burst: RTL

Parametrised memory address register for the 8-bit CPU model, successor to the single-shot MAR. It loads an address from the PC or from the data bus, then drives a burst of 1..BURST_MAX consecutive addresses to program/data memory over a req/ack handshake, auto-incrementing with wrap-around. It sits between the PC/bus and the memory block and lets the control unit fetch multi-byte instructions and operands with one load.

---
 rtl/mar_pkg.sv | 14 +
 rtl/mar_burst_if.sv | 33 +++
 rtl/mar_burst_ctr.sv | 48 ++++
 rtl/mar_burst.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mar_pkg.sv
// Shared types and helpers for the burst memory address register.
package mar_pkg;

  typedef enum logic [0:0] {
    MAR_IDLE = 1'b0,
    MAR_REQ  = 1'b1
  } mar_state_e;

  // Beat index runs 0..burst_max-1; keep at least one bit.
  function automatic int unsigned beat_w(input int unsigned burst_max);
    return (burst_max <= 1) ? 1 : $clog2(burst_max);
  endfunction

endpackage

// File: rtl/mar_burst_if.sv
// Load/memory handshake bundle between the control unit, the MAR and memory.
interface mar_burst_if #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BUS_W     = 8,
  parameter int unsigned BURST_MAX = 4
);
  localparam int unsigned LEN_W = $clog2(BURST_MAX + 1);

  logic              ld_pc;
  logic [ADDR_W-1:0] pc_addr;
  logic              ld_bus;
  logic [BUS_W-1:0]  bus_data;
  logic [LEN_W-1:0]  burst_len;
  logic [ADDR_W-1:0] lim_addr;
  logic [ADDR_W-1:0] addr;
  logic              mem_req;
  logic              mem_ack;
  logic              busy;
  logic              done;
  logic              ld_drop;
  logic              fault;

  modport master (
    output ld_pc, pc_addr, ld_bus, bus_data, burst_len, lim_addr, mem_ack,
    input  addr, mem_req, busy, done, ld_drop, fault
  );

  modport slave (
    input  ld_pc, pc_addr, ld_bus, bus_data, burst_len, lim_addr, mem_ack,
    output addr, mem_req, busy, done, ld_drop, fault
  );

endinterface

// File: rtl/mar_burst_ctr.sv
// Beat counter: captures the clamped burst length on start and flags the final beat.
module mar_burst_ctr
  import mar_pkg::*;
#(
  parameter  int unsigned BURST_MAX = 4,
  localparam int unsigned LEN_W     = $clog2(BURST_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             advance,
  input  logic [LEN_W-1:0] len_in,
  output logic             last_beat
);

  localparam int unsigned BEAT_W = beat_w(BURST_MAX);

  logic [BEAT_W-1:0] beat;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_clamp;

  // Zero means a single beat; anything above BURST_MAX saturates.
  always_comb begin
    len_clamp = len_in;
    if (len_in == '0) begin
      len_clamp = LEN_W'(1);
    end else if (len_in > LEN_W'(BURST_MAX)) begin
      len_clamp = LEN_W'(BURST_MAX);
    end
  end

  // last_beat is registered so it is valid alongside the beat it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat      <= '0;
      len       <= LEN_W'(1);
      last_beat <= 1'b0;
    end else if (start) begin
      beat      <= '0;
      len       <= len_clamp;
      last_beat <= (len_clamp == LEN_W'(1));
    end else if (advance) begin
      beat      <= beat + BEAT_W'(1);
      last_beat <= ((LEN_W'(beat) + LEN_W'(2)) == len);
    end
  end

endmodule

// File: rtl/mar_burst.sv
// Burst memory address register: loads from PC or bus, then walks 1..BURST_MAX addresses.
// Optional MAR_BOUND_CHECK_EN stops loads/increments beyond lim_addr and raises sticky fault.
module mar_burst
  import mar_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BUS_W     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input logic        clk,
  input logic        rst,
  mar_burst_if.slave mb
);

  localparam logic [0:0] ST_IDLE = 1'(MAR_IDLE);
  localparam logic [0:0] ST_REQ  = 1'(MAR_REQ);

  logic [0:0]        state;
  logic [0:0]        state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic              mem_req_q;
  logic              busy_q;
  logic              done_q;
  logic              done_nx;
  logic              drop_q;
  logic              drop_nx;
  logic              start;
  logic              advance;
  logic              last_beat;
  logic              load;
  logic [ADDR_W-1:0] src;
  logic              unused_bits;

  assign load        = mb.ld_pc | mb.ld_bus;
  assign src         = mb.ld_pc ? mb.pc_addr : mb.bus_data[ADDR_W-1:0];
  assign unused_bits = ^{mb.bus_data, mb.lim_addr};

`ifdef MAR_BOUND_CHECK_EN
  logic fault_q;
  logic fault_nx;
`endif

  mar_burst_ctr #(
    .BURST_MAX (BURST_MAX)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .advance   (advance),
    .len_in    (mb.burst_len),
    .last_beat (last_beat)
  );

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    done_nx  = 1'b0;
    drop_nx  = 1'b0;
    start    = 1'b0;
    advance  = 1'b0;
`ifdef MAR_BOUND_CHECK_EN
    fault_nx = fault_q;
`endif
    case (state)
      ST_IDLE: begin
        if (load) begin
`ifdef MAR_BOUND_CHECK_EN
          if (src > mb.lim_addr) begin
            fault_nx = 1'b1;
          end else begin
            start    = 1'b1;
            addr_nx  = src;
            state_nx = ST_REQ;
          end
`else
          start    = 1'b1;
          addr_nx  = src;
          state_nx = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        drop_nx = load;
        if (mb.mem_ack) begin
          if (last_beat) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
`ifdef MAR_BOUND_CHECK_EN
          // Next address would exceed the limit or wrap: finish on this beat.
          end else if ((addr_q >= mb.lim_addr) || (addr_q == '1)) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
            fault_nx = 1'b1;
`endif
          end else begin
            advance = 1'b1;
            addr_nx = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_q    <= addr_nx;
      mem_req_q <= (state_nx == ST_REQ);
      busy_q    <= (state_nx == ST_REQ);
      done_q    <= done_nx;
      drop_q    <= drop_nx;
    end
  end

`ifdef MAR_BOUND_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_nx;
    end
  end
  assign mb.fault = fault_q;
`else
  assign mb.fault = 1'b0;
`endif

  assign mb.addr    = addr_q;
  assign mb.mem_req = mem_req_q;
  assign mb.busy    = busy_q;
  assign mb.done    = done_q;
  assign mb.ld_drop = drop_q;

endmodule
